// File: rtl/stepper_step_gen.sv
// STEP/DIR pulse generator for one stepper axis, driven by a toggle-handshaked
// 16-bit PIO command word, with a synchronized limit-switch abort.
module stepper_step_gen #(
  parameter int DIR_SETUP = 50,
  parameter int STEP_HIGH = 250,
  parameter int STEP_LOW  = 24750
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] cmd,
  input  logic        limit_n,
  output logic        step_o,
  output logic        dir_o,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        limit_hit,
  output logic [13:0] remaining,
  output logic [2:0]  state_o
);

  localparam int MAX_A = (DIR_SETUP > STEP_HIGH) ? DIR_SETUP : STEP_HIGH;
  localparam int MAX_P = (MAX_A > STEP_LOW) ? MAX_A : STEP_LOW;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DS_LAST = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] SH_LAST = CW'(STEP_HIGH - 1);
  localparam logic [CW-1:0] SL_LAST = CW'(STEP_LOW - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          limhit_q, limhit_d;
  logic          lim_seen_q, lim_seen_d;
  logic [13:0]   rem_q, rem_d;
  logic          lim_s1_q, lim_s2_q;
  logic          prev_q, armed_q;
  logic          lim, toggle;

  assign lim    = ~lim_s2_q;
  assign toggle = armed_q && (cmd[15] != prev_q);

  // Limit synchronizer and toggle-edge tracking; nothing is accepted until
  // one clock after reset release has captured the current toggle level.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lim_s1_q <= 1'b1;
      lim_s2_q <= 1'b1;
      prev_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      lim_s1_q <= limit_n;
      lim_s2_q <= lim_s1_q;
      prev_q   <= cmd[15];
      armed_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    limhit_d   = limhit_q;
    lim_seen_d = lim_seen_q;
    rem_d      = rem_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (toggle) begin
          state_d  = S_SETUP;
          busy_d   = 1'b1;
          dir_d    = cmd[14];
          rem_d    = cmd[13:0];
          cnt_d    = '0;
          ovr_d    = 1'b0;
          limhit_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (rem_q == '0 || lim) begin
          state_d = S_DONE;
          if (lim) limhit_d = 1'b1;
        end else if (cnt_q == DS_LAST) begin
          state_d    = S_HIGH;
          step_d     = 1'b1;
          cnt_d      = '0;
          lim_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        // A started pulse always runs its full width; a limit seen meanwhile
        // is remembered and acted on at the falling edge.
        if (lim) lim_seen_d = 1'b1;
        if (cnt_q == SH_LAST) begin
          step_d = 1'b0;
          cnt_d  = '0;
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (lim_seen_q || lim) begin
            state_d  = S_DONE;
            limhit_d = 1'b1;
          end else if (rem_q <= 14'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (lim) begin
          state_d  = S_DONE;
          limhit_d = 1'b1;
        end else if (cnt_q == SL_LAST) begin
          state_d    = S_HIGH;
          step_d     = 1'b1;
          cnt_d      = '0;
          lim_seen_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    if (toggle && state_q != S_IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      limhit_q   <= 1'b0;
      lim_seen_q <= 1'b0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      limhit_q   <= limhit_d;
      lim_seen_q <= lim_seen_d;
      rem_q      <= rem_d;
    end
  end

  assign step_o    = step_q;
  assign dir_o     = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = ovr_q;
  assign limit_hit = limhit_q;
  assign remaining = rem_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// Bench for stepper_step_gen: drivers issue moves and push the expected move
// outcome; an independent monitor measures pulse timing and checks outcomes.
module tb_stepper_step_gen;

  localparam int DS = 2;
  localparam int SH = 3;
  localparam int SL = 5;
  localparam int MOVE_BUDGET = 600;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [15:0] cmd;
  logic        limit_n;
  logic        step_o, dir_o, busy, done, overrun, limit_hit;
  logic [13:0] remaining;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  // Record layout: {overrun, limit_hit, dir, count[13:0], pulses[13:0]}
  logic [30:0] exp_q[$];
  logic        tgl;

  always #5 clk_clk = ~clk_clk;

  stepper_step_gen #(
    .DIR_SETUP(DS),
    .STEP_HIGH(SH),
    .STEP_LOW (SL)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .cmd          (cmd),
    .limit_n      (limit_n),
    .step_o       (step_o),
    .dir_o        (dir_o),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .limit_hit    (limit_hit),
    .remaining    (remaining),
    .state_o      (state_o)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  int          pulses = 0;
  logic        step_p = 1'b0;
  logic        busy_p = 1'b0;
  logic        done_p = 1'b0;
  logic [30:0] rec_m;

  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      step_p = 1'b0;
      busy_p = 1'b0;
      done_p = 1'b0;
      pulses = 0;
    end else begin
      cyc++;
      if (busy && !busy_p) begin
        acc_cyc = cyc;
        pulses  = 0;
        if (exp_q.size() > 0) check("rem_at_accept", remaining, int'(exp_q[0][27:14]));
      end
      if (step_o && !step_p) begin
        check("step_while_busy", busy, 1);
        if (pulses == 0) check("first_rise_delay", cyc - acc_cyc, DS);
        else             check("step_period", cyc - last_rise, SH + SL);
        last_rise = cyc;
        pulses++;
      end
      if (!step_o && step_p) begin
        check("high_width", cyc - last_rise, SH);
        last_fall = cyc;
        if (exp_q.size() > 0) check("rem_step", remaining, int'(exp_q[0][27:14]) - pulses);
      end
      if (done) begin
        check("done_width", done_p, 0);
        if (exp_q.size() == 0) begin
          check("done_expected", 0, 1);
        end else begin
          rec_m = exp_q.pop_front();
          check("pulse_count", pulses, int'(rec_m[13:0]));
          check("dir", dir_o, int'(rec_m[28]));
          check("limit_hit", limit_hit, int'(rec_m[29]));
          check("overrun", overrun, int'(rec_m[30]));
          check("rem_final", remaining, int'(rec_m[27:14]) - int'(rec_m[13:0]));
          if (pulses == 0) check("done_latency_nostep", cyc - acc_cyc, 2);
          else             check("done_after_fall", cyc - last_fall, 1);
        end
      end
      if (done_p) check("busy_low_after_done", busy, 0);
      if (busy_p && !busy) check("busy_drop_follows_done", done_p, 1);
      step_p = step_o;
      busy_p = busy;
      done_p = done;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_move(input logic d, input int cnt, input int ovr_k, input int ovr_cnt,
                          input int lim_k, input logic lim_pre);
    int   pulses_e;
    logic lim_e;
    logic ovr_e;
    int   rises;
    int   waited;
    logic last_step;
    logic done_seen;
    pulses_e = cnt;
    lim_e    = 1'b0;
    if (lim_pre) begin
      pulses_e = 0;
      lim_e    = 1'b1;
    end else if (lim_k > 0) begin
      pulses_e = lim_k;
      lim_e    = 1'b1;
    end
    ovr_e = (ovr_k > 0);
    if (lim_pre) begin
      limit_n = 1'b0;
      repeat (3) @(posedge clk_clk);
      #1;
    end
    exp_q.push_back({ovr_e, lim_e, d, 14'(cnt), 14'(pulses_e)});
    tgl = ~tgl;
    cmd = {tgl, d, 14'(cnt)};
    rises = 0;
    waited = 0;
    last_step = 1'b0;
    done_seen = 1'b0;
    while (!done_seen && waited < MOVE_BUDGET) begin
      @(posedge clk_clk);
      #1;
      waited++;
      if (step_o && !last_step) begin
        rises++;
        if (rises == ovr_k) begin
          tgl = ~tgl;
          cmd = {tgl, cmd[14], 14'(ovr_cnt)};
        end
        if (rises == lim_k) limit_n = 1'b0;
      end
      last_step = step_o;
      if (done) done_seen = 1'b1;
    end
    check("move_done_seen", done_seen, 1);
    @(posedge clk_clk);
    #1;
    limit_n = 1'b1;
    repeat (3) @(posedge clk_clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int   c, ok, lk, gap, w;
  logic rd;

  initial begin
    tgl           = 1'b1;
    cmd           = 16'h8003;
    limit_n       = 1'b1;
    reset_reset_n = 1'b0;
    #3;
    check("reset_step", step_o, 0);
    check("reset_dir", dir_o, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    check("reset_limit_hit", limit_hit, 0);
    check("reset_remaining", remaining, 0);
    repeat (3) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (4) @(posedge clk_clk);
    #1;
    check("no_move_after_arm_busy", busy, 0);
    check("no_move_after_arm_step", step_o, 0);

    // 16'h4003: toggle 1->0, dir=1, three steps
    run_move(1'b1, 3, 0, 0, 0, 1'b0);
    // zero-count move
    run_move(1'b1, 0, 0, 0, 0, 1'b0);
    // 16'h000A with a toggle to 16'h8005 during pulse 2
    run_move(1'b0, 10, 2, 5, 0, 1'b0);
    // next toggle runs a 5-step move and clears overrun
    run_move(1'b0, 5, 0, 0, 0, 1'b0);
    // limit during pulse 4 of a 10-step move
    run_move(1'b1, 10, 0, 0, 4, 1'b0);
    // accept while limit already asserted
    run_move(1'b0, 7, 0, 0, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      c  = $urandom_range(0, 6);
      rd = 1'($urandom_range(0, 1));
      ok = 0;
      lk = 0;
      if (c >= 1 && $urandom_range(0, 3) == 0) ok = $urandom_range(1, c);
      if (c >= 2 && $urandom_range(0, 3) == 0) lk = $urandom_range(1, c - 1);
      if (lk > 0 && ok > lk) ok = lk;
      run_move(rd, c, ok, $urandom_range(1, 20), lk, 1'b0);
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk_clk);
        #1;
      end
    end

    // reset asserted in the middle of a HIGH phase
    tgl = ~tgl;
    cmd = {tgl, 1'b1, 14'd5};
    w = 0;
    while (!step_o && w < 100) begin
      @(posedge clk_clk);
      #1;
      w++;
    end
    check("reset_test_rise", step_o, 1);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    #1;
    check("midmove_reset_step", step_o, 0);
    check("midmove_reset_busy", busy, 0);
    check("midmove_reset_dir", dir_o, 0);
    check("midmove_reset_done", done, 0);
    check("midmove_reset_overrun", overrun, 0);
    check("midmove_reset_limit_hit", limit_hit, 0);
    check("midmove_reset_remaining", remaining, 0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
    check("rearm_idle", busy, 0);
    run_move(1'b0, 2, 0, 0, 0, 1'b0);

    repeat (5) @(posedge clk_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
